// File: rtl/adc_spi_rx_pkg.sv
// Shared types and constants for the serial ADC reader.
package adc_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LEAD,
        SHIFT,
        DONE
    } state_t;

    localparam int unsigned FRAME_BITS = 16;
    localparam int unsigned DATA_BITS  = 12;
    localparam int unsigned ZERO_BITS  = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_spi_rx_if.sv
// Bus between the ADC reader, the serial ADC pins and the loop controller.
interface adc_spi_rx_if;
    import adc_spi_pkg::*;

    logic                 EN;
    logic                 datoin;
    logic                 CS;
    logic                 Clkmuestreo;
    logic [ZERO_BITS-1:0] Zeros;
    logic [DATA_BITS-1:0] dato;
    logic                 dato_valid;

    modport master (
        input  EN,
        input  datoin,
        output CS,
        output Clkmuestreo,
        output Zeros,
        output dato,
        output dato_valid
    );

    modport slave (
        output EN,
        output datoin,
        input  CS,
        input  Clkmuestreo,
        input  Zeros,
        input  dato,
        input  dato_valid
    );

endinterface

// File: rtl/adc_spi_rx_spi_clk_gen.sv
// Serial clock generator: DIV-cycle phases, idles high while not running.
module spi_clk_gen
    import adc_spi_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic stop,
    output logic sclk,
    output logic rise_tick,
    output logic fall_tick,
    output logic hi_end
);

    localparam int unsigned   PW      = cnt_width(DIV);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

    logic [PW-1:0] ph;
    logic          tick;

    // Phase boundaries; with stop set a high phase ends without dropping the clock.
    always_comb begin
        tick      = run && (ph == PH_LAST);
        rise_tick = tick && !sclk;
        hi_end    = tick && sclk;
        fall_tick = hi_end && !stop;
    end

    // Phase counter and registered serial clock.
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            ph   <= '0;
            sclk <= 1'b1;
        end else begin
            if (tick) begin
                ph <= '0;
            end else begin
                ph <= ph + PW'(1);
            end
            if (rise_tick || fall_tick) begin
                sclk <= ~sclk;
            end
        end
    end

endmodule

// File: rtl/adc_spi_rx.sv
// Periodic serial-ADC frame reader: CS/clock generation, 16-bit capture, sample strobe.
module adc_spi_rx
    import adc_spi_pkg::*;
#(
    parameter int unsigned DIV           = 4,
    parameter int unsigned SAMPLE_CYCLES = 2000
) (
    input  logic         clk,
    input  logic         rst,
    adc_spi_rx_if.master bus
);

    localparam int unsigned   PW        = cnt_width(SAMPLE_CYCLES);
    localparam logic [PW-1:0] PCNT_LAST = PW'(SAMPLE_CYCLES - 1);
    localparam int unsigned   BW        = cnt_width(FRAME_BITS + 1);
    localparam logic [BW-1:0] BITS_ALL  = BW'(FRAME_BITS);

    state_t                  state;
    logic [PW-1:0]           pcnt;
    logic [BW-1:0]           bitcnt;
    logic [FRAME_BITS-1:0]   sr;
    logic                    start;
    logic                    run;
    logic                    stop;
    logic                    sclk;
    logic                    rise_tick;
    logic                    fall_tick;
    logic                    hi_end;

    // The clock generator also runs through LEAD, which is simply the first
    // high phase; this makes the first falling edge land exactly DIV cycles
    // after CS drops.
    always_comb begin
        start = (pcnt == '0) && bus.EN && (state == IDLE);
        run   = (state == LEAD) || (state == SHIFT);
        stop  = (bitcnt == BITS_ALL);
    end

    // Serial clock pin follows the registered generator output.
    always_comb begin
        bus.Clkmuestreo = sclk;
    end

    spi_clk_gen #(
        .DIV (DIV)
    ) u_clk_gen (
        .clk       (clk),
        .rst       (rst),
        .run       (run),
        .stop      (stop),
        .sclk      (sclk),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick),
        .hi_end    (hi_end)
    );

    // Conversion period counter, parked at zero while conversions are disabled.
    always_ff @(posedge clk) begin
        if (rst || !bus.EN) begin
            pcnt <= '0;
        end else if (pcnt == PCNT_LAST) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // Frame FSM with registered CS, capture shift register and sample outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.CS         <= 1'b1;
            bus.dato_valid <= 1'b0;
            bus.Zeros      <= '0;
            bus.dato       <= '0;
            sr             <= '0;
            bitcnt         <= '0;
        end else begin
            bus.dato_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= LEAD;
                        bus.CS <= 1'b0;
                        bitcnt <= '0;
                    end
                end
                LEAD: begin
                    if (fall_tick) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise_tick) begin
                        sr     <= {sr[FRAME_BITS-2:0], bus.datoin};
                        bitcnt <= bitcnt + BW'(1);
                    end
                    if (hi_end && stop) begin
                        state          <= DONE;
                        bus.CS         <= 1'b1;
                        bus.Zeros      <= sr[FRAME_BITS-1 -: ZERO_BITS];
                        bus.dato       <= sr[DATA_BITS-1:0];
                        bus.dato_valid <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
